// File: rtl/local_inject_queue.sv
// Show-ahead local injection queue feeding the injector's localadd input.
// Pops only on injector grant and flags starvation of a long-blocked head flit.
module local_inject_queue #(
  parameter int WIDTH        = 6,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         core_flit,
  input  logic                     core_valid,
  output logic                     core_ready,
  output logic [WIDTH-1:0]         inj_flit,
  output logic                     inj_valid,
  input  logic                     inj_grant,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     starve
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [7:0] LIMIT   = 8'(STARVE_LIMIT);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_nxt;
  logic [AW:0]      rd_ptr_nxt;
  logic [7:0]       starve_cnt;
  logic [7:0]       starve_cnt_nxt;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  // Wrap-bit pointers: equal means empty, low bits equal with MSBs differing means full.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign core_ready = ~full;
  assign inj_valid  = ~empty;
  assign inj_flit   = mem[rd_ptr[AW-1:0]];
  assign push       = core_valid & ~full;
  assign pop        = inj_grant & ~empty;

  // Next-state for pointers and the saturating starvation counter.
  always_comb begin
    wr_ptr_nxt     = wr_ptr;
    rd_ptr_nxt     = rd_ptr;
    starve_cnt_nxt = starve_cnt;
    if (push) begin
      wr_ptr_nxt = wr_ptr + PTR_ONE;
    end else begin
      wr_ptr_nxt = wr_ptr;
    end
    if (pop) begin
      rd_ptr_nxt = rd_ptr + PTR_ONE;
    end else begin
      rd_ptr_nxt = rd_ptr;
    end
    // Not popping while non-empty means the head was blocked this cycle.
    if (pop || empty) begin
      starve_cnt_nxt = 8'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt_nxt = starve_cnt + 8'd1;
    end else begin
      starve_cnt_nxt = starve_cnt;
    end
  end

  // Pointer, occupancy and starvation state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= 8'd0;
      starve     <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count      <= wr_ptr_nxt - rd_ptr_nxt;
      starve_cnt <= starve_cnt_nxt;
      starve     <= (starve_cnt_nxt == LIMIT);
    end
  end

  // Flit storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= core_flit;
    end
  end

endmodule

// File: tb/tb_local_inject_queue.sv
// Scoreboard bench for local_inject_queue: driver queues expected flits,
// a monitor pops and compares whenever the injector consumes the head.
module tb_local_inject_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] core_flit = 6'd0;
  logic       core_valid = 1'b0;
  logic       core_ready;
  logic [5:0] inj_flit;
  logic       inj_valid;
  logic       inj_grant = 1'b0;
  logic [2:0] count;
  logic       starve;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [5:0] exp_q [$];
  logic [5:0] mon_exp;
  int         m_cnt = 0;
  int         m_st = 0;

  local_inject_queue #(.WIDTH(6), .DEPTH(4), .STARVE_LIMIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .core_flit(core_flit), .core_valid(core_valid),
    .core_ready(core_ready), .inj_flit(inj_flit), .inj_valid(inj_valid),
    .inj_grant(inj_grant), .count(count), .starve(starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a consumed head flit must match the oldest expected flit.
  always @(negedge clk) begin
    #1;
    if (rst_n && inj_valid && inj_grant) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_order: got flit %b, expected none (scoreboard empty)", inj_flit);
      end else begin
        mon_exp = exp_q.pop_front();
        if (inj_flit !== mon_exp) begin
          n_bad++;
          $display("FAIL pop_order: got flit %b expected %b at %0t", inj_flit, mon_exp, $time);
        end
      end
    end
  end

  // One clock cycle of stimulus; the reference occupancy/starvation model advances with it.
  task automatic tick(input logic v, input logic [5:0] f, input logic g);
    logic push_ok;
    logic pop_ok;
    @(negedge clk);
    core_valid = v;
    core_flit  = f;
    inj_grant  = g;
    push_ok = v && (m_cnt < 4);
    pop_ok  = g && (m_cnt > 0);
    if (push_ok) exp_q.push_back(f);
    if (pop_ok || m_cnt == 0) m_st = 0;
    else if (m_st < 16) m_st++;
    m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
    @(posedge clk);
    #1;
    chk("count", count, m_cnt);
    chk("core_ready", core_ready, m_cnt < 4);
    chk("inj_valid", inj_valid, m_cnt > 0);
    chk("starve", starve, m_st == 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset and single flit
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_valid", inj_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", core_ready, 1);
    chk("rst_flit", inj_flit, 0);
    chk("rst_starve", starve, 0);
    tick(1'b1, 6'b100000, 1'b0);
    chk("single_flit", inj_flit, 6'b100000);
    chk("single_count", count, 1);
    tick(1'b0, 6'd0, 1'b1);
    chk("single_empty_valid", inj_valid, 0);
    chk("single_empty_count", count, 0);

    // Fill, held fifth push, full with pop, then drain in order
    tick(1'b1, 6'b000101, 1'b0);
    tick(1'b1, 6'b100001, 1'b0);
    tick(1'b1, 6'b100111, 1'b0);
    tick(1'b1, 6'b101100, 1'b0);
    chk("full_count", count, 4);
    chk("full_ready", core_ready, 0);
    tick(1'b1, 6'b010101, 1'b0);
    chk("held_count", count, 4);
    chk("held_head", inj_flit, 6'b000101);
    tick(1'b1, 6'b010101, 1'b1);
    chk("fullpop_count", count, 3);
    chk("fullpop_ready", core_ready, 1);
    chk("fullpop_head", inj_flit, 6'b100001);
    tick(1'b1, 6'b010101, 1'b0);
    chk("held_accepted", count, 4);
    for (int i = 0; i < 4; i++) tick(1'b0, 6'd0, 1'b1);
    chk("drain_count", count, 0);

    // Simultaneous push/pop with pointer wrap
    tick(1'b1, 6'b000001, 1'b0);
    tick(1'b1, 6'b000010, 1'b0);
    tick(1'b1, 6'b000011, 1'b1);
    chk("pushpop_count", count, 2);
    chk("pushpop_head", inj_flit, 6'b000010);
    for (int i = 0; i < 10; i++) tick(1'b1, 6'(6'd16 + i), 1'b1);
    chk("wrap_count", count, 2);
    chk("wrap_head", inj_flit, 6'd24);
    tick(1'b0, 6'd0, 1'b1);
    tick(1'b0, 6'd0, 1'b1);
    chk("wrap_drained", count, 0);

    // Starvation
    tick(1'b1, 6'b110011, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      tick(1'b0, 6'd0, 1'b0);
      chk("starve_low", starve, 0);
    end
    tick(1'b0, 6'd0, 1'b0);
    chk("starve_high", starve, 1);
    tick(1'b0, 6'd0, 1'b0);
    chk("starve_sat", starve, 1);
    tick(1'b0, 6'd0, 1'b1);
    chk("starve_clear", starve, 0);
    tick(1'b0, 6'd0, 1'b1);
    chk("spurious_count", count, 0);
    chk("spurious_valid", inj_valid, 0);
    chk("spurious_ready", core_ready, 1);

    // Reset mid-operation with count=3 and starve=1
    tick(1'b1, 6'b000111, 1'b0);
    tick(1'b1, 6'b001110, 1'b0);
    tick(1'b1, 6'b011100, 1'b0);
    for (int i = 0; i < 14; i++) tick(1'b0, 6'd0, 1'b0);
    chk("pre_rst_count", count, 3);
    chk("pre_rst_starve", starve, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", inj_valid, 0);
    chk("midrst_count", count, 0);
    chk("midrst_ready", core_ready, 1);
    chk("midrst_flit", inj_flit, 0);
    chk("midrst_starve", starve, 0);
    exp_q.delete();
    m_cnt = 0;
    m_st  = 0;
    rst_n = 1'b1;
    tick(1'b1, 6'b100000, 1'b0);
    chk("post_rst_flit", inj_flit, 6'b100000);
    chk("post_rst_count", count, 1);
    tick(1'b0, 6'd0, 1'b1);
    chk("post_rst_empty", inj_valid, 0);
    tick(1'b0, 6'd0, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
